// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control unit: state codes, opcode/funct
// values, ALU operation codes and the decoded-instruction record.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_IF  = 4'd0;
    localparam logic [3:0] ST_ID  = 4'd1;
    localparam logic [3:0] ST_EXE = 4'd2;
    localparam logic [3:0] ST_WB  = 4'd3;
    localparam logic [3:0] ST_MA  = 4'd4;
    localparam logic [3:0] ST_MEM = 4'd5;
    localparam logic [3:0] ST_LWB = 4'd6;
    localparam logic [3:0] ST_BR  = 4'd7;
    localparam logic [3:0] ST_ILL = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_ADDU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILL
    } ins_cls_e;

    typedef struct packed {
        ins_cls_e   cls;
        logic [3:0] alu;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic       src_a;
        logic       src_b;
    } dec_t;

    // Branch condition from the ALU flags of rs-rt (beq/bne) or rs-0 (the rest).
    function automatic logic br_taken(input logic [5:0] op, input logic zf, input logic sf);
        case (op)
            OP_BEQ:  return zf;
            OP_BNE:  return !zf;
            OP_BLTZ: return sf;
            OP_BLEZ: return sf | zf;
            OP_BGTZ: return !sf && !zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle. The control unit uses the master modport,
// the datapath (or a bench standing in for it) uses the slave modport.
interface mc_ctrl_fsm_if #(
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned CNT_W  = 32
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              zf;
    logic              sf;
    logic              mem_ready;

    logic              pc_wr;
    logic              ir_wr;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              alu_src_a;
    logic              alu_src_b;
    logic              data_src;
    logic              wr_data_src;
    logic              ext_sel;
    logic [1:0]        pc_src;
    logic [1:0]        reg_dst;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [3:0]        state_o;
    logic              illegal;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;

    modport master (
        input  opcode, funct, zf, sf, mem_ready,
        output pc_wr, ir_wr, reg_wr, mem_rd, mem_wr,
        output alu_src_a, alu_src_b, data_src, wr_data_src, ext_sel,
        output pc_src, reg_dst, alu_ctrl, state_o, illegal,
        output cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, funct, zf, sf, mem_ready,
        input  pc_wr, ir_wr, reg_wr, mem_rd, mem_wr,
        input  alu_src_a, alu_src_b, data_src, wr_data_src, ext_sel,
        input  pc_src, reg_dst, alu_ctrl, state_o, illegal,
        input  cycle_cnt, instret_cnt
    );

endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: opcode/funct -> instruction class, ALU code,
// immediate extension, destination-register select and ALU operand selects.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o         = '0;
        dec_o.cls     = CLS_ILL;
        dec_o.alu     = ALU_ADD;
        dec_o.reg_dst = 2'b01;

        case (opcode_i)
            OP_RTYPE: begin
                dec_o.cls     = CLS_ALU_R;
                dec_o.reg_dst = 2'b10;
                case (funct_i)
                    FN_ADD:  dec_o.alu = ALU_ADD;
                    FN_ADDU: dec_o.alu = ALU_ADDU;
                    FN_SUB:  dec_o.alu = ALU_SUB;
                    FN_AND:  dec_o.alu = ALU_AND;
                    FN_OR:   dec_o.alu = ALU_OR;
                    FN_XOR:  dec_o.alu = ALU_XOR;
                    FN_NOR:  dec_o.alu = ALU_NOR;
                    FN_SLT:  dec_o.alu = ALU_SLT;
                    FN_SLTU: dec_o.alu = ALU_SLTU;
                    FN_SLL: begin
                        dec_o.alu   = ALU_SLL;
                        dec_o.src_a = 1'b1;
                    end
                    FN_SRL: begin
                        dec_o.alu   = ALU_SRL;
                        dec_o.src_a = 1'b1;
                    end
                    FN_JR:   dec_o.cls = CLS_JR;
                    default: dec_o.cls = CLS_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_o.cls   = CLS_ALU_I;
                dec_o.src_b = 1'b1;
                case (opcode_i)
                    OP_ADDI:  dec_o.alu = ALU_ADD;
                    OP_ADDIU: dec_o.alu = ALU_ADDU;
                    OP_SLTI:  dec_o.alu = ALU_SLT;
                    OP_SLTIU: dec_o.alu = ALU_SLTU;
                    OP_ANDI:  dec_o.alu = ALU_AND;
                    OP_ORI:   dec_o.alu = ALU_OR;
                    default:  dec_o.alu = ALU_XOR;
                endcase
                // Logical immediates are zero-extended, arithmetic/compare ones sign-extended.
                dec_o.ext_sel = !(opcode_i == OP_ANDI || opcode_i == OP_ORI || opcode_i == OP_XORI);
            end
            OP_LW, OP_SW: begin
                dec_o.cls     = (opcode_i == OP_LW) ? CLS_LW : CLS_SW;
                dec_o.ext_sel = 1'b1;
                dec_o.src_b   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLTZ, OP_BLEZ, OP_BGTZ: begin
                dec_o.cls     = CLS_BR;
                dec_o.alu     = ALU_SUB;
                dec_o.ext_sel = 1'b1;
            end
            OP_J:    dec_o.cls = CLS_J;
            OP_JAL: begin
                dec_o.cls     = CLS_JAL;
                dec_o.reg_dst = 2'b00;
            end
            default: dec_o.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM with mem_ready handshake and illegal-instruction halt.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned CNT_W  = 32
)(
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    dec_t       dec;

    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] pc_src;
    logic       data_src;
    logic       wr_data_src;

    mc_ctrl_dec u_dec (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .dec_o    (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        pc_src      = 2'b00;
        data_src    = 1'b0;
        wr_data_src = 1'b1;

        case (state_q)
            ST_IF: begin
                mem_rd = 1'b1;
                ir_wr  = bus.mem_ready;
                pc_wr  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                case (dec.cls)
                    CLS_ALU_R, CLS_ALU_I: state_d = ST_EXE;
                    CLS_LW, CLS_SW:       state_d = ST_MA;
                    CLS_BR:               state_d = ST_BR;
                    CLS_J: begin
                        pc_wr   = 1'b1;
                        pc_src  = 2'b11;
                        state_d = ST_IF;
                    end
                    CLS_JAL: begin
                        pc_wr       = 1'b1;
                        pc_src      = 2'b11;
                        reg_wr      = 1'b1;
                        wr_data_src = 1'b0;
                        state_d     = ST_IF;
                    end
                    CLS_JR: begin
                        pc_wr   = 1'b1;
                        pc_src  = 2'b10;
                        state_d = ST_IF;
                    end
                    default: state_d = ST_ILL;
                endcase
            end
            ST_EXE: state_d = ST_WB;
            ST_WB: begin
                reg_wr  = 1'b1;
                state_d = ST_IF;
            end
            ST_MA: state_d = ST_MEM;
            ST_MEM: begin
                mem_rd = (dec.cls == CLS_LW);
                mem_wr = (dec.cls != CLS_LW);
                if (bus.mem_ready) begin
                    state_d = (dec.cls == CLS_LW) ? ST_LWB : ST_IF;
                end
            end
            ST_LWB: begin
                reg_wr   = 1'b1;
                data_src = 1'b1;
                state_d  = ST_IF;
            end
            ST_BR: begin
                pc_src  = 2'b01;
                pc_wr   = br_taken(bus.opcode, bus.zf, bus.sf);
                state_d = ST_IF;
            end
            ST_ILL: state_d = ST_ILL;
            default: state_d = ST_IF;
        endcase
    end

    // Strobes are gated by rst so an access in flight is dropped the moment reset asserts.
    assign bus.pc_wr       = pc_wr  & rst;
    assign bus.ir_wr       = ir_wr  & rst;
    assign bus.reg_wr      = reg_wr & rst;
    assign bus.mem_rd      = mem_rd & rst;
    assign bus.mem_wr      = mem_wr & rst;
    assign bus.pc_src      = pc_src;
    assign bus.data_src    = data_src;
    assign bus.wr_data_src = wr_data_src;
    assign bus.alu_src_a   = dec.src_a;
    assign bus.alu_src_b   = dec.src_b;
    assign bus.ext_sel     = dec.ext_sel;
    assign bus.reg_dst     = dec.reg_dst;
    assign bus.alu_ctrl    = ALUC_W'(dec.alu);
    assign bus.state_o     = state_q;
    assign bus.illegal     = (state_q == ST_ILL);

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else if (state_q != ST_ILL) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (state_d == ST_IF && state_q != ST_IF) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`else
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
    assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: ID-decode vector table, directed multi-cycle sequences and
// randomized instruction streams checked against an instruction-level expected trace.
module tb_mc_ctrl_fsm;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] alu;
        logic       ext;
        logic       ext_chk;
        logic       shamt;
        logic       imm;
    } ins_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [4:0] strb;
        logic [1:0] pc_src;
        logic       pcs_chk;
        logic [1:0] rdst;
        logic       ds;
        logic       wds;
        logic       wr_chk;
        logic       alu_chk;
        logic [3:0] alu;
        logic       sa;
        logic       sb;
        logic       ext_chk;
        logic       ext;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] nxt;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       reg_wr;
        logic       ext_chk;
        logic       ext;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALUC_W(AW), .CNT_W(CW)) bus ();
    mc_ctrl_fsm #(.ALUC_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;
    ins_t lib[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn, input int kind,
                                input logic [3:0] alu, input logic ext, input logic ext_chk,
                                input logic shamt, input logic imm);
        ins_t r;
        r.op = op; r.fn = fn; r.kind = kind; r.alu = alu;
        r.ext = ext; r.ext_chk = ext_chk; r.shamt = shamt; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t mv(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] nxt,
                                input logic pc_wr, input logic [1:0] pc_src, input logic reg_wr,
                                input logic ext_chk, input logic ext);
        vec_t v;
        v.op = op; v.fn = fn; v.nxt = nxt; v.pc_wr = pc_wr; v.pc_src = pc_src;
        v.reg_wr = reg_wr; v.ext_chk = ext_chk; v.ext = ext;
        return v;
    endfunction

    function automatic cyc_t blank(input logic [3:0] st, input logic mr);
        cyc_t c;
        c.st = st; c.mr = mr; c.strb = 5'b0; c.pc_src = 2'b00; c.pcs_chk = 1'b0;
        c.rdst = 2'b00; c.ds = 1'b0; c.wds = 1'b1; c.wr_chk = 1'b0; c.alu_chk = 1'b0;
        c.alu = 4'b0; c.sa = 1'b0; c.sb = 1'b0; c.ext_chk = 1'b0; c.ext = 1'b0;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef MC_PERF_CNT_EN
        return 32'(n % 16);
`else
        return 32'(n * 0);
`endif
    endfunction

    function automatic logic [31:0] strobes();
        return 32'({bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_rd, bus.mem_wr});
    endfunction

    task automatic cmp(input cyc_t e, input string tag);
        chk({tag, " state"}, 32'(bus.state_o), 32'(e.st));
        chk({tag, " strobes"}, strobes(), 32'(e.strb));
        chk({tag, " illegal"}, 32'(bus.illegal), 32'(e.st == 4'd8));
        if (e.pcs_chk) chk({tag, " pc_src"}, 32'(bus.pc_src), 32'(e.pc_src));
        if (e.wr_chk) begin
            chk({tag, " reg_dst"}, 32'(bus.reg_dst), 32'(e.rdst));
            chk({tag, " data_src"}, 32'(bus.data_src), 32'(e.ds));
            chk({tag, " wr_data_src"}, 32'(bus.wr_data_src), 32'(e.wds));
        end
        if (e.alu_chk) begin
            chk({tag, " alu_ctrl"}, 32'(bus.alu_ctrl), 32'(e.alu));
            chk({tag, " alu_src_a"}, 32'(bus.alu_src_a), 32'(e.sa));
            chk({tag, " alu_src_b"}, 32'(bus.alu_src_b), 32'(e.sb));
        end
        if (e.ext_chk) chk({tag, " ext_sel"}, 32'(bus.ext_sel), 32'(e.ext));
    endtask

    // Expected per-cycle trace of one instruction, from fetch to the return to IF.
    task automatic run_instr(input ins_t in, input int fw, input int mw,
                             input logic zf, input logic sf, input string tag);
        cyc_t q[$];
        cyc_t c;
        logic taken;
        bus.opcode = in.op; bus.funct = in.fn; bus.zf = zf; bus.sf = sf;
        for (int i = 0; i < fw; i++) begin
            c = blank(4'd0, 1'b0); c.strb = 5'b00010; c.pcs_chk = 1'b1; q.push_back(c);
        end
        c = blank(4'd0, 1'b1); c.strb = 5'b11010; c.pcs_chk = 1'b1; q.push_back(c);
        c = blank(4'd1, rbit());
        if (in.kind == K_J)   begin c.strb = 5'b10000; c.pc_src = 2'b11; c.pcs_chk = 1'b1; end
        if (in.kind == K_JR)  begin c.strb = 5'b10000; c.pc_src = 2'b10; c.pcs_chk = 1'b1; end
        if (in.kind == K_JAL) begin
            c.strb = 5'b10100; c.pc_src = 2'b11; c.pcs_chk = 1'b1;
            c.wr_chk = 1'b1; c.rdst = 2'b00; c.ds = 1'b0; c.wds = 1'b0;
        end
        q.push_back(c);
        if (in.kind == K_R || in.kind == K_I) begin
            c = blank(4'd2, rbit());
            c.alu_chk = 1'b1; c.alu = in.alu; c.sa = in.shamt; c.sb = in.imm;
            c.ext_chk = in.ext_chk; c.ext = in.ext;
            q.push_back(c);
            c.st = 4'd3; c.mr = rbit(); c.strb = 5'b00100; c.wr_chk = 1'b1;
            c.rdst = (in.kind == K_R) ? 2'b10 : 2'b01; c.ds = 1'b0; c.wds = 1'b1;
            q.push_back(c);
        end
        if (in.kind == K_LW || in.kind == K_SW) begin
            c = blank(4'd4, rbit());
            c.alu_chk = 1'b1; c.alu = 4'b0100; c.sb = 1'b1; c.ext_chk = 1'b1; c.ext = 1'b1;
            q.push_back(c);
            for (int i = 0; i <= mw; i++) begin
                c = blank(4'd5, (i == mw));
                c.strb = (in.kind == K_LW) ? 5'b00010 : 5'b00001;
                q.push_back(c);
            end
            if (in.kind == K_LW) begin
                c = blank(4'd6, rbit()); c.strb = 5'b00100; c.wr_chk = 1'b1;
                c.rdst = 2'b01; c.ds = 1'b1; c.wds = 1'b1;
                q.push_back(c);
            end
        end
        if (in.kind == K_BR) begin
            case (in.op)
                6'h04:   taken = zf;
                6'h05:   taken = !zf;
                6'h01:   taken = sf;
                6'h06:   taken = sf | zf;
                default: taken = !sf && !zf;
            endcase
            c = blank(4'd7, rbit());
            c.strb = taken ? 5'b10000 : 5'b00000; c.pc_src = 2'b01; c.pcs_chk = 1'b1;
            c.alu_chk = 1'b1; c.alu = 4'b0110; c.ext_chk = 1'b1; c.ext = 1'b1;
            q.push_back(c);
        end
        foreach (q[i]) begin
            bus.mem_ready = q[i].mr;
            @(negedge clk);
            cmp(q[i], tag);
            @(posedge clk);
            #1;
        end
        retired++;
        chk({tag, " instret"}, 32'(bus.instret_cnt), exp_cnt(retired));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        retired = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.zf = 1'b0; bus.sf = 1'b0;
        bus.mem_ready = 1'b1;
        rst = 1'b0;

        lib.push_back(mk(6'h00, 6'h20, K_R, 4'b0100, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h21, K_R, 4'b0101, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h22, K_R, 4'b0110, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h24, K_R, 4'b0000, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h25, K_R, 4'b0001, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h26, K_R, 4'b1010, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h27, K_R, 4'b0011, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h2a, K_R, 4'b1001, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h2b, K_R, 4'b1000, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h00, K_R, 4'b0010, 0, 0, 1, 0));
        lib.push_back(mk(6'h00, 6'h02, K_R, 4'b0111, 0, 0, 1, 0));
        lib.push_back(mk(6'h08, 6'h15, K_I, 4'b0100, 1, 1, 0, 1));
        lib.push_back(mk(6'h09, 6'h3f, K_I, 4'b0101, 1, 1, 0, 1));
        lib.push_back(mk(6'h0a, 6'h00, K_I, 4'b1001, 1, 1, 0, 1));
        lib.push_back(mk(6'h0b, 6'h08, K_I, 4'b1000, 1, 1, 0, 1));
        lib.push_back(mk(6'h0c, 6'h20, K_I, 4'b0000, 0, 1, 0, 1));
        lib.push_back(mk(6'h0d, 6'h2a, K_I, 4'b0001, 0, 1, 0, 1));
        lib.push_back(mk(6'h0e, 6'h01, K_I, 4'b1010, 0, 1, 0, 1));
        lib.push_back(mk(6'h23, 6'h11, K_LW, 4'b0100, 1, 1, 0, 1));
        lib.push_back(mk(6'h2b, 6'h04, K_SW, 4'b0100, 1, 1, 0, 1));
        lib.push_back(mk(6'h04, 6'h00, K_BR, 4'b0110, 1, 1, 0, 0));
        lib.push_back(mk(6'h05, 6'h00, K_BR, 4'b0110, 1, 1, 0, 0));
        lib.push_back(mk(6'h01, 6'h00, K_BR, 4'b0110, 1, 1, 0, 0));
        lib.push_back(mk(6'h06, 6'h00, K_BR, 4'b0110, 1, 1, 0, 0));
        lib.push_back(mk(6'h07, 6'h00, K_BR, 4'b0110, 1, 1, 0, 0));
        lib.push_back(mk(6'h02, 6'h00, K_J,  4'b0100, 0, 0, 0, 0));
        lib.push_back(mk(6'h03, 6'h00, K_JAL, 4'b0100, 0, 0, 0, 0));
        lib.push_back(mk(6'h00, 6'h08, K_JR, 4'b0100, 0, 0, 0, 0));

        // op, funct, next state after ID, ID pc_wr/pc_src/reg_wr, ext_sel check
        vecs.push_back(mv(6'h00, 6'h20, 4'd2, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mv(6'h00, 6'h00, 4'd2, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mv(6'h00, 6'h08, 4'd0, 1, 2'b10, 0, 0, 0));
        vecs.push_back(mv(6'h00, 6'h3f, 4'd8, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mv(6'h08, 6'h00, 4'd2, 0, 2'b00, 0, 1, 1));
        vecs.push_back(mv(6'h0d, 6'h00, 4'd2, 0, 2'b00, 0, 1, 0));
        vecs.push_back(mv(6'h23, 6'h00, 4'd4, 0, 2'b00, 0, 1, 1));
        vecs.push_back(mv(6'h2b, 6'h00, 4'd4, 0, 2'b00, 0, 1, 1));
        vecs.push_back(mv(6'h04, 6'h00, 4'd7, 0, 2'b00, 0, 1, 1));
        vecs.push_back(mv(6'h01, 6'h00, 4'd7, 0, 2'b00, 0, 1, 1));
        vecs.push_back(mv(6'h02, 6'h00, 4'd0, 1, 2'b11, 0, 0, 0));
        vecs.push_back(mv(6'h03, 6'h00, 4'd0, 1, 2'b11, 1, 0, 0));
        vecs.push_back(mv(6'h3f, 6'h20, 4'd8, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mv(6'h0f, 6'h00, 4'd8, 0, 2'b00, 0, 0, 0));

        // Reset state: IF, but every strobe held low while rst is asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state", 32'(bus.state_o), 32'd0);
        chk("reset strobes", strobes(), 32'd0);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        chk("reset cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
        chk("reset instret_cnt", 32'(bus.instret_cnt), 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            bus.opcode = vecs[i].op; bus.funct = vecs[i].fn; bus.mem_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1 bus.mem_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d ID state", i), 32'(bus.state_o), 32'd1);
            chk($sformatf("vec%0d ID pc_wr", i), 32'(bus.pc_wr), 32'(vecs[i].pc_wr));
            chk($sformatf("vec%0d ID reg_wr", i), 32'(bus.reg_wr), 32'(vecs[i].reg_wr));
            if (vecs[i].pc_wr) chk($sformatf("vec%0d ID pc_src", i), 32'(bus.pc_src), 32'(vecs[i].pc_src));
            if (vecs[i].ext_chk) chk($sformatf("vec%0d ext_sel", i), 32'(bus.ext_sel), 32'(vecs[i].ext));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("vec%0d next state", i), 32'(bus.state_o), 32'(vecs[i].nxt));
        end

        do_reset();
        run_instr(lib[0], 0, 0, 1'b0, 1'b0, "add");
        run_instr(lib[18], 1, 3, 1'b0, 1'b0, "lw wait3");
        run_instr(lib[19], 0, 0, 1'b0, 1'b0, "sw ready");
        run_instr(lib[20], 0, 0, 1'b1, 1'b0, "beq zf1");
        run_instr(lib[20], 2, 0, 1'b0, 1'b0, "beq zf0");
        run_instr(lib[23], 0, 0, 1'b1, 1'b0, "blez zf1");
        run_instr(lib[26], 0, 0, 1'b0, 1'b0, "jal");

        // Illegal opcode: halt in ILL with strobes low, counters frozen after two live cycles.
        do_reset();
        bus.opcode = 6'h3f; bus.funct = 6'h00; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = rbit();
            @(negedge clk);
            chk("ill state", 32'(bus.state_o), 32'd8);
            chk("ill strobes", strobes(), 32'd0);
            chk("ill illegal", 32'(bus.illegal), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("ill cycle_cnt frozen", 32'(bus.cycle_cnt), exp_cnt(2));
        chk("ill instret_cnt", 32'(bus.instret_cnt), exp_cnt(0));
        rst = 1'b0;
        #1;
        chk("ill reset illegal", 32'(bus.illegal), 32'd0);
        chk("ill reset state", 32'(bus.state_o), 32'd0);

        // Reset asserted mid-read must drop mem_rd immediately.
        do_reset();
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst mem_rd before", strobes(), 32'b00010);
        #2 rst = 1'b0;
        #1;
        chk("midrst strobes", strobes(), 32'd0);
        chk("midrst state", 32'(bus.state_o), 32'd0);

        // Counter wrap at CNT_W=4 with fetch stalled: no instruction retires.
        do_reset();
        bus.mem_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1 || k == 15 || k == 16)
                chk($sformatf("cycle_cnt k=%0d", k), 32'(bus.cycle_cnt), exp_cnt(k));
        end
        chk("stall instret", 32'(bus.instret_cnt), exp_cnt(0));
        chk("stall state", 32'(bus.state_o), 32'd0);

        do_reset();
        for (int n = 0; n < 150; n++) begin
            int unsigned idx;
            idx = $urandom_range(0, lib.size() - 1);
            run_instr(lib[idx], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      rbit(), rbit(), $sformatf("rnd%0d op%0h fn%0h", n, lib[idx].op, lib[idx].fn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
